pipe_mem_acc: RTL and testbench
===============================

PIPE_MEM_ACC -- requirements
Module: pipe_mem_acc

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 clr  in  1  reset, synchronous, active-high.
REQ-003 malu  in  32  MEM-stage ALU result / memory address.
REQ-004 mb  in  32  MEM-stage store data.
REQ-005 mrn  in  5  MEM-stage destination register.
REQ-006 mwreg, mm2reg, mwmem  in  1 each  MEM-stage controls: register write, load, store.
REQ-007 dmem_req  out  1  data-memory request, registered.
REQ-008 dmem_we  out  1  write enable, registered, valid while dmem_req=1.
REQ-009 dmem_addr, dmem_wdata  out  32 each  registered address / store data.
REQ-010 dmem_ack  in  1  memory completion strobe; one cycle per request.
REQ-011 dmem_rdata  in  32  load data, valid in the dmem_ack cycle.
REQ-012 mstall  out  1  combinational; holds IF..EXE/MEM stages while 1.
REQ-013 wwreg, wm2reg  out  1 each  MEM/WB controls.
REQ-014 wmo, walu  out  32 each  MEM/WB load data, ALU result.
REQ-015 wrn  out  5  MEM/WB destination register.
REQ-016 merr  out  1  sticky memory-timeout flag.

Function
REQ-017 acc = mm2reg | mwmem; FSM has exactly two states, IDLE and REQ.
REQ-018 Non-memory op (acc=0) in IDLE: mstall=0, MEM/WB captures next edge; latency 1 cycle.
REQ-019 IDLE with acc=1: mstall=1; next edge -> REQ, dmem_req<=1, dmem_addr<=malu, dmem_wdata<=mb, dmem_we<=mwmem, timeout counter<=0.
REQ-020 REQ, dmem_ack=0: mstall=1, dmem_* held stable, counter increments by 1 (4-bit).
REQ-021 REQ, dmem_ack=1: mstall=0; next edge -> IDLE, dmem_req<=0, wmo<=dmem_rdata, other MEM/WB fields captured from inputs.
REQ-022 Minimum memory-op latency 2 cycles (ack in first REQ cycle); no upper bound below timeout.
REQ-023 Edge with mstall=1: wwreg<=0, wm2reg<=0 (bubble); walu, wmo, wrn hold.
REQ-024 Edge with mstall=0: wwreg<=mwreg, wm2reg<=mm2reg & ~mwmem, walu<=malu, wrn<=mrn; wmo<=dmem_rdata only on ack completion, else holds.
REQ-025 mm2reg=mwmem=1 (illegal): executed as store; dmem_we=1; wm2reg=0.
REQ-026 Timeout: REQ with counter=15 and dmem_ack=0 -> mstall=0 that cycle; next edge -> IDLE, dmem_req<=0, merr<=1, wwreg<=0 (instruction squashed).
REQ-027 Ack at counter=15 completes normally; no timeout.
REQ-028 dmem_ack in IDLE is ignored: no state, output or merr change.
REQ-029 merr stays 1 until clr; later accesses proceed normally.
REQ-030 Exactly one request per instruction: no re-issue after completion, because the upstream advances on the completing edge.

Reset
REQ-031 clr=1 at an edge: state<=IDLE, counter<=0, dmem_req<=0, dmem_we<=0, dmem_addr<=0, dmem_wdata<=0, wwreg<=0, wm2reg<=0, wmo<=0, walu<=0, wrn<=0, merr<=0.
REQ-032 clr during REQ abandons the transaction; dmem_req=0 from the next cycle; a late dmem_ack is ignored per REQ-028.
REQ-033 While clr=1, mstall follows REQ-018/019 combinationally, but no state updates.

Verification
REQ-034 ALU op malu=0x12345678, mrn=5, mwreg=1 -> mstall=0; next cycle walu=0x12345678, wrn=5, wwreg=1; dmem_req stays 0.
REQ-035 Load malu=0x100, mrn=3, ack 3 cycles after dmem_req, rdata=0xCAFEF00D -> mstall=1 for 4 cycles; wwreg=0 during stall; then wmo=0xCAFEF00D, wm2reg=1, wrn=3.
REQ-036 Store malu=0x200, mb=0xDEADBEEF, immediate ack -> dmem_req=1, dmem_we=1, addr=0x200, wdata=0xDEADBEEF for exactly 1 cycle; mstall high 1 cycle; wwreg=0.
REQ-037 Load with no ack -> dmem_req high 16 cycles, then drops; merr=1; wwreg=0; next ALU op completes normally with merr still 1.
REQ-038 clr asserted on the 2nd REQ cycle, ack arrives 1 cycle later -> dmem_req=0 and all outputs 0 after the edge; the ack causes no change.
REQ-039 Back-to-back load then store, each acked immediately -> two distinct requests, 2 cycles each; no duplicate request; load result written once.

Source files
------------

// File: rtl/pipe_mem_acc.sv
// MEM-stage data-memory access unit with MEM/WB pipeline register.
// Issues one registered request per load/store and stalls upstream until ack or timeout.
module pipe_mem_acc (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mstall,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic [4:0]  wrn,
    output logic        merr
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] cnt_reg;

    logic acc;
    logic issue;
    logic done_ack;
    logic time_out;

    // A load-and-store combination is treated as a store (dmem_we follows mwmem).
    assign acc = mm2reg | mwmem;

    always_comb begin
        state_next = state_reg;
        mstall     = 1'b0;
        issue      = 1'b0;
        done_ack   = 1'b0;
        time_out   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (acc) begin
                    mstall     = 1'b1;
                    issue      = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (dmem_ack) begin
                    done_ack   = 1'b1;
                    state_next = S_IDLE;
                end else if (cnt_reg == 4'hF) begin
                    // Release the pipeline so the faulting instruction drains as a bubble.
                    time_out   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    mstall = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_reg <= 4'd0;
        end else if (issue) begin
            cnt_reg <= 4'd0;
        end else if (state_reg == S_REQ && mstall) begin
            cnt_reg <= cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
        end else if (issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mwmem;
            dmem_addr  <= malu;
            dmem_wdata <= mb;
        end else if (done_ack || time_out) begin
            dmem_req <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            merr <= 1'b0;
        end else if (time_out) begin
            merr <= 1'b1;
        end
    end

    // MEM/WB register: a stall or a timed-out access inserts a bubble and holds data.
    always_ff @(posedge clk) begin
        if (clr) begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
            wmo    <= 32'd0;
            walu   <= 32'd0;
            wrn    <= 5'd0;
        end else if (mstall || time_out) begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
        end else begin
            wwreg  <= mwreg;
            wm2reg <= mm2reg & ~mwmem;
            walu   <= malu;
            wrn    <= mrn;
            if (done_ack) begin
                wmo <= dmem_rdata;
            end
        end
    end

    a_req_matches_state: assert property (@(posedge clk) disable iff (clr)
        dmem_req == (state_reg == S_REQ));

    a_req_held_while_waiting: assert property (@(posedge clk) disable iff (clr)
        (state_reg == S_REQ && mstall) |=>
            (dmem_req && $stable(dmem_addr) && $stable(dmem_wdata) && $stable(dmem_we)));

endmodule

// File: tb/tb_pipe_mem_acc.sv
// Self-checking bench for pipe_mem_acc: directed scenarios plus randomized
// instruction streams against a transaction-level latency/result model.
module tb_pipe_mem_acc;

    logic        clk;
    logic        clr;
    logic [31:0] malu;
    logic [31:0] mb;
    logic [4:0]  mrn;
    logic        mwreg;
    logic        mm2reg;
    logic        mwmem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mstall;
    logic        wwreg;
    logic        wm2reg;
    logic [31:0] wmo;
    logic [31:0] walu;
    logic [4:0]  wrn;
    logic        merr;

    int total = 0;
    int bad   = 0;

    // Architectural expectations for the MEM/WB fields that hold across bubbles.
    logic [31:0] m_walu;
    logic [31:0] m_wmo;
    logic [4:0]  m_wrn;
    logic        m_merr;

    pipe_mem_acc dut (
        .clk        (clk),
        .clr        (clr),
        .malu       (malu),
        .mb         (mb),
        .mrn        (mrn),
        .mwreg      (mwreg),
        .mm2reg     (mm2reg),
        .mwmem      (mwmem),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .mstall     (mstall),
        .wwreg      (wwreg),
        .wm2reg     (wm2reg),
        .wmo        (wmo),
        .walu       (walu),
        .wrn        (wrn),
        .merr       (merr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_nop();
        malu   = 32'd0;
        mb     = 32'd0;
        mrn    = 5'd0;
        mwreg  = 1'b0;
        mm2reg = 1'b0;
        mwmem  = 1'b0;
    endtask

    task automatic model_clear();
        m_walu = 32'd0;
        m_wmo  = 32'd0;
        m_wrn  = 5'd0;
        m_merr = 1'b0;
    endtask

    // One instruction through MEM. delay = index of the request cycle that gets
    // the ack; negative or >15 means the memory never answers (timeout).
    // Called and returns at a falling edge.
    task automatic do_op(input bit ld, input bit st, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rn, input bit wr,
                         input int delay, input logic [31:0] rd);
        bit acc, to, done, exp_wwreg, exp_wm2;
        int k, stalls, reqs, exp_cyc;
        acc = ld | st;
        to  = acc && (delay < 0 || delay > 15);
        k   = to ? 15 : delay;
        exp_cyc = acc ? k + 1 : 0;
        malu = a; mb = b; mrn = rn; mwreg = wr; mm2reg = ld; mwmem = st;
        dmem_rdata = rd;
        dmem_ack = 1'b0;
        stalls = 0; reqs = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (stalls > 0) begin
                total++;
                if (wwreg !== 1'b0 || wm2reg !== 1'b0 || walu !== m_walu) begin
                    bad++;
                    $display("FAIL bubble: wwreg=%0b wm2reg=%0b walu=%h, required 0 0 %h",
                             wwreg, wm2reg, walu, m_walu);
                end
            end
            if (dmem_req === 1'b1) begin
                dmem_ack = !to && (reqs == delay);
                total++;
                if (dmem_addr !== a || dmem_wdata !== b || dmem_we !== st) begin
                    bad++;
                    $display("FAIL req_fields: addr=%h wdata=%h we=%0b, required %h %h %0b",
                             dmem_addr, dmem_wdata, dmem_we, a, b, st);
                end
                reqs++;
            end else begin
                dmem_ack = 1'b0;
            end
            #1;
            if (mstall === 1'b1) stalls++;
            else done = 1;
            @(posedge clk);
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL bound: mstall never released after 40 cycles");
        end
        if (!to) begin
            exp_wwreg = wr;
            exp_wm2   = ld & ~st;
            m_walu    = a;
            m_wrn     = rn;
            if (acc) m_wmo = rd;
        end else begin
            exp_wwreg = 1'b0;
            exp_wm2   = 1'b0;
            m_merr    = 1'b1;
        end
        total++;
        if (stalls != exp_cyc) begin
            bad++;
            $display("FAIL stall_cycles: got %0d, required %0d", stalls, exp_cyc);
        end
        total++;
        if (reqs != exp_cyc) begin
            bad++;
            $display("FAIL req_cycles: got %0d, required %0d", reqs, exp_cyc);
        end
        total++;
        if (dmem_req !== 1'b0) begin
            bad++;
            $display("FAIL req_drop: dmem_req=%0b, required 0", dmem_req);
        end
        total++;
        if (wwreg !== exp_wwreg || wm2reg !== exp_wm2) begin
            bad++;
            $display("FAIL wb_ctrl: wwreg=%0b wm2reg=%0b, required %0b %0b",
                     wwreg, wm2reg, exp_wwreg, exp_wm2);
        end
        total++;
        if (walu !== m_walu || wrn !== m_wrn || wmo !== m_wmo) begin
            bad++;
            $display("FAIL wb_data: walu=%h wrn=%0d wmo=%h, required %h %0d %h",
                     walu, wrn, wmo, m_walu, m_wrn, m_wmo);
        end
        total++;
        if (merr !== m_merr) begin
            bad++;
            $display("FAIL merr: got %0b, required %0b", merr, m_merr);
        end
        $display("op ld=%0b st=%0b addr=%h wdata=%h rn=%0d delay=%0d stalls=%0d reqs=%0d merr=%0b",
                 ld, st, a, b, rn, delay, stalls, reqs, merr);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        set_nop();
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, wwreg, wm2reg, wmo, walu, wrn, merr, mstall} !== '0) begin
            bad++;
            $display("FAIL reset_state: req=%0b we=%0b addr=%h wdata=%h wwreg=%0b wm2reg=%0b wmo=%h walu=%h wrn=%0d merr=%0b mstall=%0b, required all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, wwreg, wm2reg, wmo, walu, wrn, merr, mstall);
        end
        mm2reg = 1'b1;
        #1;
        total++;
        if (mstall !== 1'b1) begin
            bad++;
            $display("FAIL reset_mstall: mstall=%0b, required 1", mstall);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (dmem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: dmem_req=%0b, required 0", dmem_req);
        end
        set_nop();
        clr = 1'b0;
        model_clear();
        $display("reset done");
    endtask

    task automatic test_alu();
        do_op(1'b0, 1'b0, 32'h12345678, 32'h0, 5'd5, 1'b1, 0, 32'h0);
    endtask

    task automatic test_load();
        do_op(1'b1, 1'b0, 32'h100, 32'h0, 5'd3, 1'b1, 3, 32'hCAFEF00D);
    endtask

    task automatic test_store();
        do_op(1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 5'd0, 1'b0, 0, 32'h0BADF00D);
    endtask

    task automatic test_idle_ack();
        malu = m_walu; mb = 32'h55; mrn = m_wrn;
        mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = ~m_wmo;
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;
        total++;
        if (wmo !== m_wmo || dmem_req !== 1'b0 || merr !== m_merr) begin
            bad++;
            $display("FAIL idle_ack: wmo=%h req=%0b merr=%0b, required %h 0 %0b",
                     wmo, dmem_req, merr, m_wmo, m_merr);
        end
        $display("idle ack ignored check wmo=%h", wmo);
    endtask

    task automatic test_timeout();
        do_op(1'b1, 1'b0, 32'h300, 32'h0, 5'd7, 1'b1, -1, 32'h11112222);
        do_op(1'b0, 1'b0, 32'hA5A5A5A5, 32'h0, 5'd9, 1'b1, 0, 32'h0);
        do_op(1'b1, 1'b0, 32'h304, 32'h0, 5'd8, 1'b1, 15, 32'h33334444);
    endtask

    task automatic test_back_to_back();
        do_op(1'b1, 1'b0, 32'h400, 32'h0, 5'd12, 1'b1, 0, 32'h600DF00D);
        do_op(1'b0, 1'b1, 32'h404, 32'h87654321, 5'd0, 1'b0, 0, 32'h600DF00D);
    endtask

    task automatic test_illegal();
        do_op(1'b1, 1'b1, 32'h500, 32'h13579BDF, 5'd4, 1'b0, 1, 32'h24680ACE);
    endtask

    task automatic test_clr_mid();
        malu = 32'h700; mb = 32'h0; mrn = 5'd6;
        mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        total++;
        if (dmem_req !== 1'b1 || mstall !== 1'b1) begin
            bad++;
            $display("FAIL clr_mid_pre: req=%0b mstall=%0b, required 1 1", dmem_req, mstall);
        end
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        set_nop();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFEEDFACE;
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;
        model_clear();
        total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, wwreg, wm2reg, wmo, walu, wrn, merr} !== '0) begin
            bad++;
            $display("FAIL clr_mid: req=%0b we=%0b addr=%h wdata=%h wwreg=%0b wm2reg=%0b wmo=%h walu=%h wrn=%0d merr=%0b, required all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, wwreg, wm2reg, wmo, walu, wrn, merr);
        end
        $display("clr during request check req=%0b wmo=%h", dmem_req, wmo);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int kind, dly;
            bit ld, st;
            kind = $urandom_range(0, 3);
            ld = (kind == 1) || (kind == 3);
            st = (kind == 2) || (kind == 3);
            dly = ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(0, 6);
            do_op(ld, st, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), dly, $urandom);
        end
    endtask

    initial begin
        clr = 1'b1;
        set_nop();
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_idle_ack();
        test_timeout();
        test_back_to_back();
        test_illegal();
        test_clr_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
